fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001: Parameter DEPTH, default 4, number of 64-bit fetch-bundle entries; SHALL be a power of two, at least 2.
REQ-002: clock_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-003: reset_n_i  input  1  reset, synchronous and active-low.
REQ-004: push_valid_i  input  1  a fetch bundle from the F2 instruction-memory stage is present.
REQ-005: push_data_i  input  64  bundle data: [31:0] is the instruction at push_pc_i, [63:32] is the instruction at push_pc_i+4.
REQ-006: push_pc_i  input  32  PC of the bundle's low instruction.
REQ-007: push_ready_o  output  1  queue can accept a bundle this cycle.
REQ-008: consume_i  input  2  decode/issue take from the head: 00 none, 01 slot0 only, 11 both; 10 SHALL be ignored.
REQ-009: flush_i  input  1  redirect or mispredict: discard all entries.
REQ-010: inst0_valid_o / inst1_valid_o  output  1 each  head slots are valid.
REQ-011: inst0_o / inst1_o  output  32 each  head instructions presented to decode.
REQ-012: pc0_o / pc1_o  output  32 each  PCs of inst0_o and inst1_o.
REQ-013: count_o  output  log2(DEPTH)+1  number of occupied entries.

Function
REQ-014: Storage SHALL be a circular buffer of DEPTH entries, each holding data[63:0], pc[31:0] and a half flag; head and tail pointers SHALL wrap modulo DEPTH.
REQ-015: push_ready_o SHALL equal (count_o < DEPTH), computed from registered state only; there is no pass-through when full, even if the same cycle pops.
REQ-016: A push happens when push_valid_i && push_ready_o && !flush_i; the entry is written at the tail with half=0 and tail advances by one.
REQ-017: Write-to-read latency SHALL be 1 cycle: a bundle pushed into an empty queue appears on the outputs in the following cycle.
REQ-018: Head with half=0: inst0_o = data[31:0], pc0_o = pc, inst1_o = data[63:32], pc1_o = pc+4, and both valids are 1.
REQ-019: Head with half=1: inst0_o = data[63:32], pc0_o = pc+4, inst0_valid_o = 1, inst1_valid_o = 0, inst1_o = 0, pc1_o = 0.
REQ-020: Empty queue: both valids are 0, and all instruction and PC outputs are 0.
REQ-021: consume_i=11 with half=0 SHALL pop the head entry.
REQ-022: consume_i=01 with half=0 SHALL set half=1 and not pop.
REQ-023: consume_i=01 or 11 with half=1 SHALL pop the head; with 11, the slot1 take is ignored because that slot is invalid.
REQ-024: consume_i is ignored when the queue is empty or when the slot0 take does not match a valid slot.
REQ-025: A simultaneous push and pop SHALL leave count_o unchanged, with both pointers advancing.
REQ-026: flush_i SHALL have priority over push and consume: on the next cycle count_o = 0, head = tail, and all half flags are cleared.
REQ-027: count_o SHALL never exceed DEPTH or go below 0 under any input combination.

Reset
REQ-028: While reset_n_i = 0 at a clock edge, head, tail, count_o and all half flags SHALL be cleared to 0, and push and consume SHALL be ignored.
REQ-029: Outputs in reset and the cycle after: count_o = 0, both valids = 0, data and PC outputs = 0, push_ready_o = 1.
REQ-030: Reset asserted mid-operation SHALL discard all contents, exactly as a flush does.

Verification
REQ-031: Reset, then push {0x00200093_00100013, pc 0x100} -> next cycle: inst0_o = 0x00100013, pc0_o = 0x100, inst1_o = 0x00200093, pc1_o = 0x104, count_o = 1.
REQ-032: With that bundle at the head, consume_i = 01 -> inst0_o = 0x00200093, pc0_o = 0x104, inst1_valid_o = 0, count_o = 1; then consume_i = 01 -> empty, count_o = 0.
REQ-033: Push 4 bundles (pc 0x0, 0x8, 0x10, 0x18) with no consume -> push_ready_o = 0 and a 5th push is dropped; then push and consume_i = 11 in the same cycle -> still dropped, count_o = 3, and the head shows pc 0x8.
REQ-034: Push 10 bundles while consuming 11 every cycle -> order is preserved across pointer wrap-around, with pc0_o stepping by 8 and count_o staying ≤ 1.
REQ-035: Queue holding 3 bundles, with flush_i, push_valid_i and consume_i = 11 in the same cycle -> next cycle count_o = 0, both valids = 0, and the pushed bundle is not stored.
REQ-036: Queue holding 2 bundles, reset_n_i low for 1 cycle mid-stream -> count_o = 0, and push_ready_o = 1 afterwards.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer of 64-bit fetch bundles sitting between the
// F2 instruction-memory stage and decode. Each entry carries two 32-bit
// instructions, the PC of the low one, and a half flag recording that slot0
// of the entry has already been taken by decode.
//
// Ports:
//   clock_i, reset_n_i        clock, synchronous active-low reset
//   push_valid_i/data_i/pc_i  incoming bundle from F2
//   push_ready_o              queue has a free entry (registered state only)
//   consume_i                 decode take: 00 none, 01 slot0, 11 both, 10 ignored
//   flush_i                   discard all entries (priority over push/consume)
//   inst{0,1}_valid_o, inst{0,1}_o, pc{0,1}_o   head instructions for decode
//   count_o                   number of occupied entries
module fetch_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock_i,
    input  logic                     reset_n_i,
    input  logic                     push_valid_i,
    input  logic [63:0]              push_data_i,
    input  logic [31:0]              push_pc_i,
    output logic                     push_ready_o,
    input  logic [1:0]               consume_i,
    input  logic                     flush_i,
    output logic                     inst0_valid_o,
    output logic                     inst1_valid_o,
    output logic [31:0]              inst0_o,
    output logic [31:0]              inst1_o,
    output logic [31:0]              pc0_o,
    output logic [31:0]              pc1_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [63:0]    data_q [DEPTH];
    logic [31:0]    pc_q   [DEPTH];
    logic [DEPTH-1:0] half_q;
    logic [PW-1:0]  head_q;
    logic [PW-1:0]  tail_q;
    logic [CW-1:0]  count_q;

    logic empty_c;
    logic head_half_c;
    logic do_push_c;
    logic do_pop_c;
    logic set_half_c;

    // Push/pop decisions from registered state and this cycle's requests.
    always_comb begin
        empty_c      = (count_q == CW'(0));
        head_half_c  = half_q[head_q];
        push_ready_o = (count_q < CW'(DEPTH));
        do_push_c    = reset_n_i && !flush_i && push_valid_i && push_ready_o;
        // A slot0 take is required; slot1 take only matters while slot1 is valid.
        do_pop_c     = reset_n_i && !flush_i && !empty_c && consume_i[0]
                       && (consume_i[1] || head_half_c);
        set_half_c   = reset_n_i && !flush_i && !empty_c && consume_i[0]
                       && !consume_i[1] && !head_half_c;
    end

    // Control state: pointers, occupancy and half flags.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            half_q  <= '0;
        end else if (flush_i) begin
            head_q  <= tail_q;
            count_q <= '0;
            half_q  <= '0;
        end else begin
            // head and tail only coincide when empty or full, so the push and
            // pop half-flag writes never hit the same entry.
            if (do_push_c) begin
                tail_q         <= tail_q + PW'(1);
                half_q[tail_q] <= 1'b0;
            end
            if (do_pop_c) begin
                head_q         <= head_q + PW'(1);
                half_q[head_q] <= 1'b0;
            end
            if (set_half_c) begin
                half_q[head_q] <= 1'b1;
            end
            count_q <= count_q + CW'(do_push_c) - CW'(do_pop_c);
        end
    end

    // Bundle storage; contents are don't-care until written.
    always_ff @(posedge clock_i) begin
        if (do_push_c) begin
            data_q[tail_q] <= push_data_i;
            pc_q[tail_q]   <= push_pc_i;
        end
    end

    // Head presentation to decode.
    always_comb begin
        inst0_valid_o = 1'b0;
        inst1_valid_o = 1'b0;
        inst0_o       = '0;
        inst1_o       = '0;
        pc0_o         = '0;
        pc1_o         = '0;
        if (!empty_c) begin
            inst0_valid_o = 1'b1;
            if (!head_half_c) begin
                inst0_o       = data_q[head_q][31:0];
                pc0_o         = pc_q[head_q];
                inst1_valid_o = 1'b1;
                inst1_o       = data_q[head_q][63:32];
                pc1_o         = pc_q[head_q] + 32'd4;
            end else begin
                inst0_o       = data_q[head_q][63:32];
                pc0_o         = pc_q[head_q] + 32'd4;
            end
        end
    end

    assign count_o = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a queue model.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;

    logic        clock_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        push_valid_i = 1'b0;
    logic [63:0] push_data_i = '0;
    logic [31:0] push_pc_i = '0;
    logic        push_ready_o;
    logic [1:0]  consume_i = 2'b00;
    logic        flush_i = 1'b0;
    logic        inst0_valid_o;
    logic        inst1_valid_o;
    logic [31:0] inst0_o;
    logic [31:0] inst1_o;
    logic [31:0] pc0_o;
    logic [31:0] pc1_o;
    logic [2:0]  count_o;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clock_i       (clock_i),
        .reset_n_i     (reset_n_i),
        .push_valid_i  (push_valid_i),
        .push_data_i   (push_data_i),
        .push_pc_i     (push_pc_i),
        .push_ready_o  (push_ready_o),
        .consume_i     (consume_i),
        .flush_i       (flush_i),
        .inst0_valid_o (inst0_valid_o),
        .inst1_valid_o (inst1_valid_o),
        .inst0_o       (inst0_o),
        .inst1_o       (inst1_o),
        .pc0_o         (pc0_o),
        .pc1_o         (pc1_o),
        .count_o       (count_o)
    );

    always #5 clock_i = ~clock_i;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    // Model: FIFO of {pc, data} bundles plus "slot0 of head already taken".
    logic [95:0] m_q[$];
    logic        m_half = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic rst, input logic pv, input logic [63:0] d,
                              input logic [31:0] pc, input logic [1:0] cons, input logic fl);
        logic pushing;
        if (rst || fl) begin
            m_q.delete();
            m_half = 1'b0;
        end else begin
            pushing = pv && (m_q.size() < DEPTH);
            if (m_q.size() > 0 && cons[0]) begin
                if (cons[1] || m_half) begin
                    void'(m_q.pop_front());
                    m_half = 1'b0;
                end else begin
                    m_half = 1'b1;
                end
            end
            if (pushing) m_q.push_back({pc, d});
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clock_i) begin
        if (chk_en) begin
            logic [31:0] e_i0, e_i1, e_p0, e_p1;
            logic        e_v0, e_v1;
            logic [95:0] ent;
            e_i0 = '0; e_i1 = '0; e_p0 = '0; e_p1 = '0; e_v0 = 1'b0; e_v1 = 1'b0;
            if (m_q.size() > 0) begin
                ent  = m_q[0];
                e_v0 = 1'b1;
                if (!m_half) begin
                    e_v1 = 1'b1;
                    e_i0 = ent[31:0];
                    e_i1 = ent[63:32];
                    e_p0 = ent[95:64];
                    e_p1 = ent[95:64] + 32'd4;
                end else begin
                    e_i0 = ent[63:32];
                    e_p0 = ent[95:64] + 32'd4;
                end
            end
            chk("count", 64'(count_o), 64'(m_q.size()));
            chk("ready", 64'(push_ready_o), 64'(m_q.size() < DEPTH));
            chk("v0", 64'(inst0_valid_o), 64'(e_v0));
            chk("v1", 64'(inst1_valid_o), 64'(e_v1));
            chk("inst0", 64'(inst0_o), 64'(e_i0));
            chk("inst1", 64'(inst1_o), 64'(e_i1));
            chk("pc0", 64'(pc0_o), 64'(e_p0));
            chk("pc1", 64'(pc1_o), 64'(e_p1));
        end
    end

    // One clock cycle with the given inputs; model follows the same edge.
    task automatic cyc(input logic rst, input logic pv, input logic [63:0] d,
                       input logic [31:0] pc, input logic [1:0] cons, input logic fl);
        reset_n_i    = !rst;
        push_valid_i = pv;
        push_data_i  = d;
        push_pc_i    = pc;
        consume_i    = cons;
        flush_i      = fl;
        @(posedge clock_i);
        model_step(rst, pv, d, pc, cons, fl);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 64'd0, 32'd0, 2'b00, 1'b0);
    endtask

    task automatic push(input logic [63:0] d, input logic [31:0] pc, input logic [1:0] cons);
        cyc(1'b0, 1'b1, d, pc, cons, 1'b0);
    endtask

    initial begin
        // Reset
        cyc(1'b1, 1'b0, 64'd0, 32'd0, 2'b00, 1'b0);
        chk_en = 1'b1;
        cyc(1'b1, 1'b1, 64'hdead, 32'h40, 2'b11, 1'b0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_ready", 64'(push_ready_o), 64'd1);
        chk("rst_v0", 64'(inst0_valid_o), 64'd0);
        idle();
        chk("post_rst_count", 64'(count_o), 64'd0);
        chk("post_rst_ready", 64'(push_ready_o), 64'd1);

        // Single bundle, one-cycle latency
        push(64'h00200093_00100013, 32'h100, 2'b00);
        chk("b_inst0", 64'(inst0_o), 64'h00100013);
        chk("b_pc0", 64'(pc0_o), 64'h100);
        chk("b_inst1", 64'(inst1_o), 64'h00200093);
        chk("b_pc1", 64'(pc1_o), 64'h104);
        chk("b_count", 64'(count_o), 64'd1);

        // Slot0-only takes
        cyc(1'b0, 1'b0, 64'd0, 32'd0, 2'b01, 1'b0);
        chk("h_inst0", 64'(inst0_o), 64'h00200093);
        chk("h_pc0", 64'(pc0_o), 64'h104);
        chk("h_v1", 64'(inst1_valid_o), 64'd0);
        chk("h_count", 64'(count_o), 64'd1);
        cyc(1'b0, 1'b0, 64'd0, 32'd0, 2'b01, 1'b0);
        chk("h2_count", 64'(count_o), 64'd0);
        chk("h2_v0", 64'(inst0_valid_o), 64'd0);

        // Fill, overflow, push+pop while full
        for (int i = 0; i < 4; i++) push({32'(i + 32'h10), 32'(i)}, 32'(i * 8), 2'b00);
        chk("full_ready", 64'(push_ready_o), 64'd0);
        chk("full_count", 64'(count_o), 64'd4);
        push(64'h55, 32'h20, 2'b00);
        chk("drop_count", 64'(count_o), 64'd4);
        push(64'h66, 32'h28, 2'b11);
        chk("pp_count", 64'(count_o), 64'd3);
        chk("pp_pc0", 64'(pc0_o), 64'h8);

        // Flush beats push and consume
        cyc(1'b0, 1'b1, 64'h77, 32'h30, 2'b11, 1'b1);
        chk("fl_count", 64'(count_o), 64'd0);
        chk("fl_v0", 64'(inst0_valid_o), 64'd0);
        chk("fl_v1", 64'(inst1_valid_o), 64'd0);
        idle();
        chk("fl_idle_count", 64'(count_o), 64'd0);

        // Mid-stream reset
        push(64'h1, 32'h500, 2'b00);
        push(64'h2, 32'h508, 2'b00);
        cyc(1'b1, 1'b0, 64'd0, 32'd0, 2'b00, 1'b0);
        chk("mr_count", 64'(count_o), 64'd0);
        idle();
        chk("mr_ready", 64'(push_ready_o), 64'd1);

        // Streaming through pointer wrap-around
        for (int k = 0; k < 10; k++) begin
            push({32'(k), 32'(k + 1000)}, 32'h200 + 32'(k * 8), 2'b11);
            chk("wr_pc0", 64'(pc0_o), 64'h200 + 64'(k * 8));
            chk("wr_count", 64'(count_o), 64'd1);
        end
        cyc(1'b0, 1'b0, 64'd0, 32'd0, 2'b11, 1'b0);
        chk("wr_drain", 64'(count_o), 64'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 9) < 7),
                {$urandom, $urandom},
                $urandom & 32'hffff_fffc,
                2'($urandom),
                ($urandom_range(0, 29) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
